// File: rtl/c1541_sd_pkg.sv
// Shared types and constants for the 1541 SD-card request arbiter.
package c1541_sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int          NDRV_MAX    = 4;
  localparam logic [23:0] TIMEOUT_DEF = 24'hFFFFFF;

endpackage

// File: rtl/c1541_rr_pick.sv
// Round-robin picker: first pending requester searching upward from last+1.
module c1541_rr_pick
  import c1541_sd_pkg::*;
#(
  parameter int N = NDRV_MAX
) (
  input  logic [N-1:0] pending,
  input  logic [1:0]   last,
  output logic         valid,
  output logic [1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(last) + k) % N;
      if (!valid && pending[j]) begin
        valid = 1'b1;
        idx   = 2'(j);
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arb.sv
// Arbitrates up to four 1541 drive engines onto one host SD block interface.
module c1541_sd_arb
  import c1541_sd_pkg::*;
#(
  parameter int          NDRV    = 4,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [32*NDRV-1:0]   drv_lba,
  input  logic [6*NDRV-1:0]    drv_blk_cnt,
  input  logic [NDRV-1:0]      drv_rd,
  input  logic [NDRV-1:0]      drv_wr,
  output logic [NDRV-1:0]      drv_ack,
  input  logic [8*NDRV-1:0]    drv_buff_din,
  output logic [NDRV-1:0]      drv_buff_wr,
  output logic [31:0]          sd_lba,
  output logic [5:0]           sd_blk_cnt,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din,
  output logic                 busy,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  arb_state_t      state;
  logic [1:0]      last_grant;
  logic [23:0]     cnt;
  logic [23:0]     cnt_next;
  logic [NDRV-1:0] pending;
  logic            pick_valid;
  logic [1:0]      pick_idx;
  logic            active;

  assign pending  = drv_rd | drv_wr;
  assign cnt_next = (cnt == 24'hFFFFFF) ? cnt : cnt + 24'd1;
  assign active   = (state == ST_ISSUE) || (state == ST_XFER);
  assign busy     = (state != ST_IDLE);

  c1541_rr_pick #(.N(NDRV)) u_pick (
    .pending (pending),
    .last    (last_grant),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // Host ack and buffer strobes are routed only to the granted drive.
  always_comb begin
    for (int i = 0; i < NDRV; i++) begin
      drv_ack[i] = sd_ack && active && (grant == 2'(i));
    end
  end

  assign drv_buff_wr = drv_ack & {NDRV{sd_buff_wr}};
  assign sd_buff_din = drv_buff_din[grant*8 +: 8];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      sd_lba      <= '0;
      sd_blk_cnt  <= '0;
      grant       <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last_grant  <= 2'(NDRV - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant      <= pick_idx;
            sd_lba     <= drv_lba[pick_idx*32 +: 32];
            sd_blk_cnt <= drv_blk_cnt[pick_idx*6 +: 6];
            // Write wins when a drive raises both strobes.
            sd_wr      <= drv_wr[pick_idx];
            sd_rd      <= ~drv_wr[pick_idx];
            cnt        <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_XFER;
          end else if (!pending[grant]) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_next;
            if (cnt_next >= TIMEOUT) begin
              sd_rd       <= 1'b0;
              sd_wr       <= 1'b0;
              timeout_err <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_XFER: begin
          if (!sd_ack) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          last_grant <= grant;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_sd_arb.sv
// Bench for c1541_sd_arb: directed table, corner sequences, randomized round-robin traffic.
module tb_c1541_sd_arb;

  localparam int NDRV = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [32*NDRV-1:0] drv_lba;
  logic [6*NDRV-1:0]  drv_blk_cnt;
  logic [NDRV-1:0]    drv_rd;
  logic [NDRV-1:0]    drv_wr;
  logic [NDRV-1:0]    drv_ack;
  logic [8*NDRV-1:0]  drv_buff_din;
  logic [NDRV-1:0]    drv_buff_wr;
  logic [31:0]        sd_lba;
  logic [5:0]         sd_blk_cnt;
  logic               sd_rd;
  logic               sd_wr;
  logic               sd_ack;
  logic               sd_buff_wr;
  logic [7:0]         sd_buff_din;
  logic               busy;
  logic [1:0]         grant;
  logic               timeout_err;

  c1541_sd_arb #(.NDRV(NDRV), .TIMEOUT(24'd16)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  // clock/reset
  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int model_last = NDRV - 1;
  // expected {grant, sd_wr, sd_rd, blk_cnt, lba} per granted request
  logic [41:0] exp_q[$];

  typedef struct {
    int          drv;
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // reference: first pending drive upward from last+1, wrapping
  function automatic int rr_model(input logic [NDRV-1:0] pend, input int last);
    for (int s = 1; s <= NDRV; s++) begin
      if (pend[(last + s) % NDRV]) return (last + s) % NDRV;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    drv_rd = '0; drv_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_rdwr", {sd_rd, sd_wr}, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_blk", sd_blk_cnt, 0);
    check("rst_grant", grant, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_ack", drv_ack, 0);
    reset_n = 1'b1;
    model_last = NDRV - 1;
  endtask

  // driver: waits for an issued request, checks it, then plays the host side
  task automatic serve(input int nbytes, input int delay, output int g);
    int n = 0;
    logic [41:0] e;
    logic [7:0] b;
    while (!(sd_rd || sd_wr) && n < 40) begin step(); n++; end
    if (!(sd_rd || sd_wr)) begin
      check("issue_wait", 0, 1);
      g = -1;
      return;
    end
    g = int'(grant);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
      check("grant_word", {grant, sd_wr, sd_rd, sd_blk_cnt, sd_lba}, e);
    end
    drv_lba[g*32 +: 32]   = $urandom();
    drv_blk_cnt[g*6 +: 6] = 6'($urandom());
    repeat (delay) step();
    sd_ack = 1'b1;
    #1;
    check("ack_route", drv_ack, 1 << g);
    step();
    check("xfer_rdwr", {sd_rd, sd_wr}, 0);
    check("xfer_hold", {sd_blk_cnt, sd_lba}, e[37:0]);
    for (int i = 0; i < nbytes; i++) begin
      sd_buff_wr = 1'b1;
      b = 8'($urandom());
      drv_buff_din[g*8 +: 8] = b;
      #1;
      check("buff_wr_route", drv_buff_wr, 1 << g);
      check("buff_din_mux", sd_buff_din, b);
      step();
    end
    sd_buff_wr = 1'b0;
    drv_rd[g] = 1'b0;
    drv_wr[g] = 1'b0;
    sd_ack = 1'b0;
    step();
    check("release_busy", busy, 1);
    step();
    check("idle_busy", busy, 0);
    model_last = g;
  endtask

  // scoreboard invariants checked every cycle
  always @(negedge clk_sys) begin
    check("ack_onehot", ($countones(drv_ack) <= 1), 1);
    check("buff_wr_gated", drv_buff_wr & ~drv_ack, 0);
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int g;
    logic [NDRV-1:0] pend;
    int op;
    tbl[0] = '{2, 1'b1, 1'b0, 32'h0000_0120, 6'd7,  1'b1, 1'b0};
    tbl[1] = '{1, 1'b1, 1'b1, 32'h0000_0005, 6'd0,  1'b0, 1'b1};
    tbl[2] = '{3, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'd63, 1'b0, 1'b1};
    tbl[3] = '{0, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd1,  1'b1, 1'b0};

    drv_lba = '0; drv_blk_cnt = '0; drv_buff_din = '0;
    do_reset();

    // table-driven single-drive transfers
    for (int t = 0; t < 4; t++) begin
      drv_lba[tbl[t].drv*32 +: 32]   = tbl[t].lba;
      drv_blk_cnt[tbl[t].drv*6 +: 6] = tbl[t].blk;
      drv_rd[tbl[t].drv] = tbl[t].rd;
      drv_wr[tbl[t].drv] = tbl[t].wr;
      exp_q.push_back({2'(tbl[t].drv), tbl[t].exp_wr, tbl[t].exp_rd, tbl[t].blk, tbl[t].lba});
      check("pre_issue_rdwr", {sd_rd, sd_wr}, 0);
      step();
      check("issue_latency", {sd_rd, sd_wr}, {tbl[t].exp_rd, tbl[t].exp_wr});
      serve(8, 1, g);
    end

    // simultaneous requests after reset, then drive 0 re-requests behind drive 1
    do_reset();
    for (int d = 0; d < NDRV; d++) begin
      drv_lba[d*32 +: 32] = 32'h100 + d;
      drv_blk_cnt[d*6 +: 6] = 6'(d);
    end
    drv_rd = 4'b1011;
    exp_q.push_back({2'd0, 1'b0, 1'b1, 6'd0, 32'h100});
    exp_q.push_back({2'd1, 1'b0, 1'b1, 6'd1, 32'h101});
    exp_q.push_back({2'd3, 1'b0, 1'b1, 6'd3, 32'h103});
    serve(2, 0, g);
    drv_lba[31:0] = 32'h200;
    drv_blk_cnt[5:0] = 6'd9;
    drv_rd[0] = 1'b1;
    exp_q.push_back({2'd0, 1'b0, 1'b1, 6'd9, 32'h200});
    serve(1, 0, g);
    serve(1, 0, g);
    serve(1, 0, g);

    // host never acks: timeout after 16 ISSUE cycles, then next request served
    drv_rd[2] = 1'b1;
    step();
    begin
      int n = 0;
      while (sd_rd && n < 40) begin n++; step(); end
      check("timeout_len", n, 16);
    end
    check("timeout_pulse", timeout_err, 1);
    check("timeout_idle", busy, 0);
    drv_rd[2] = 1'b0;
    drv_lba[63:32] = 32'h77;
    drv_blk_cnt[11:6] = 6'd4;
    drv_rd[1] = 1'b1;
    exp_q.push_back({2'd1, 1'b0, 1'b1, 6'd4, 32'h77});
    step();
    check("timeout_one_cycle", timeout_err, 0);
    serve(2, 0, g);

    // request withdrawn in ISSUE: late ack must not be routed
    drv_rd[0] = 1'b1;
    step();
    check("wd_issue", sd_rd, 1);
    step();
    drv_rd[0] = 1'b0;
    step();
    check("wd_idle", {busy, sd_rd}, 0);
    sd_ack = 1'b1;
    #1;
    check("wd_no_ack", drv_ack, 0);
    step();
    check("wd_no_ack2", {busy, drv_ack}, 0);
    sd_ack = 1'b0;
    step();

    // reset mid-XFER abandons the transfer
    drv_rd[1] = 1'b1;
    step();
    sd_ack = 1'b1;
    step();
    sd_buff_wr = 1'b1;
    #1;
    check("mid_xfer_ack", drv_ack, 4'b0010);
    reset_n = 1'b0;
    step();
    check("rst_xfer_rdwr", {sd_rd, sd_wr}, 0);
    check("rst_xfer_ack", drv_ack, 0);
    check("rst_xfer_bwr", drv_buff_wr, 0);
    check("rst_xfer_busy", busy, 0);
    drv_rd = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    reset_n = 1'b1;
    model_last = NDRV - 1;
    drv_lba[31:0] = 32'h10; drv_blk_cnt[5:0] = 6'd2;
    drv_lba[95:64] = 32'h12; drv_blk_cnt[17:12] = 6'd5;
    drv_rd[0] = 1'b1; drv_rd[2] = 1'b1;
    exp_q.push_back({2'd0, 1'b0, 1'b1, 6'd2, 32'h10});
    exp_q.push_back({2'd2, 1'b0, 1'b1, 6'd5, 32'h12});
    serve(1, 0, g);
    serve(1, 0, g);

    // randomized traffic against the round-robin reference
    for (int it = 0; it < 40; it++) begin
      for (int d = 0; d < NDRV; d++) begin
        if (!drv_rd[d] && !drv_wr[d] && $urandom_range(0, 1) == 1) begin
          op = $urandom_range(0, 2);
          drv_rd[d] = (op != 1);
          drv_wr[d] = (op != 0);
          drv_lba[d*32 +: 32] = $urandom();
          drv_blk_cnt[d*6 +: 6] = 6'($urandom());
        end
      end
      if ((drv_rd | drv_wr) == '0) begin
        op = $urandom_range(0, NDRV - 1);
        drv_rd[op] = 1'b1;
        drv_lba[op*32 +: 32] = $urandom();
      end
      pend = drv_rd | drv_wr;
      g = rr_model(pend, model_last);
      exp_q.push_back({2'(g), drv_wr[g], ~drv_wr[g], drv_blk_cnt[g*6 +: 6], drv_lba[g*32 +: 32]});
      serve($urandom_range(0, 3), $urandom_range(0, 3), g);
    end

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
